debounce_bank: RTL and testbench

DEBOUNCE_BANK -- requirements
Module: debounce_bank

---
 rtl/debounce_bank.sv | 137 +++++++++++++
 tb/tb_debounce_bank.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// Multi-channel switch/key debouncer: synchroniser, shared sample-tick prescaler,
// and a per-channel settle FSM producing registered levels and edge pulses.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// STABLE   | s matches dout; counter held at 0
// SETTLING | s differs from dout; counter tallies consecutive differing ticks
module debounce_bank #(
  parameter int   CHANNELS      = 2,
  parameter int   STABLE_CYCLES = 20,
  parameter int   PRESCALE      = 1,
  parameter int   SYNC_STAGES   = 2,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] dout,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                changed
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic {STABLE, SETTLING} state_t;

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] s;
  logic [CHANNELS-1:0] differ;
  logic [PW-1:0]       pre_cnt;
  logic                tick;

  state_t              state_q [CHANNELS];
  state_t              state_d [CHANNELS];
  logic [CW-1:0]       cnt_q   [CHANNELS];
  logic [CW-1:0]       cnt_d   [CHANNELS];
  logic [CHANNELS-1:0] dout_d;
  logic [CHANNELS-1:0] rise_d;
  logic [CHANNELS-1:0] fall_d;
  logic [CHANNELS-1:0] accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= {CHANNELS{RESET_LEVEL}};
    end else begin
      sync_q[0] <= din;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s      = sync_q[SYNC_STAGES-1];
  assign differ = s ^ dout;

  // With PRESCALE=1 the count stays at 0 == PRE_LAST, so tick is constantly high.
  always_ff @(posedge clk) begin
    if (rst)                   pre_cnt <= '0;
    else if (pre_cnt == PRE_LAST) pre_cnt <= '0;
    else                       pre_cnt <= pre_cnt + PW'(1);
  end

  assign tick = (pre_cnt == PRE_LAST);

  always_comb begin
    dout_d = dout;
    rise_d = '0;
    fall_d = '0;
    accept = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (tick) begin
        unique case (state_q[i])
          STABLE: begin
            if (differ[i]) begin
              if (STABLE_CYCLES == 1) begin
                accept[i] = 1'b1;
              end else begin
                state_d[i] = SETTLING;
                cnt_d[i]   = CW'(1);
              end
            end else begin
              cnt_d[i] = '0;
            end
          end
          SETTLING: begin
            if (!differ[i]) begin
              state_d[i] = STABLE;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
              accept[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
          default: begin
            state_d[i] = STABLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
      if (accept[i]) begin
        state_d[i] = STABLE;
        cnt_d[i]   = '0;
        dout_d[i]  = s[i];
        rise_d[i]  = s[i];
        fall_d[i]  = ~s[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
      dout    <= {CHANNELS{RESET_LEVEL}};
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      dout    <= dout_d;
      rise    <= rise_d;
      fall    <= fall_d;
      changed <= |(rise_d | fall_d);
    end
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: default instance (PRESCALE=1) plus a PRESCALE=4
// instance; table of {din, edges, expected outputs} followed by corner sequences.
module tb_debounce_bank;

  logic       clk;
  logic       rst;
  logic [1:0] din, dout, rise, fall;
  logic       changed;
  logic [1:0] din4, dout4, rise4, fall4;
  logic       changed4;

  int n_vec = 0;
  int n_bad = 0;

  debounce_bank dut (
    .clk(clk), .rst(rst), .din(din), .dout(dout),
    .rise(rise), .fall(fall), .changed(changed)
  );

  debounce_bank #(.PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst), .din(din4), .dout(dout4),
    .rise(rise4), .fall(fall4), .changed(changed4)
  );

  typedef struct packed {
    logic [1:0] din;
    logic [7:0] n;
    logic [1:0] dout;
    logic [1:0] rise;
    logic [1:0] fall;
    logic       changed;
  } vec_t;

  vec_t tbl [15];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse sanity on every cycle, both instances.
  always @(negedge clk) begin
    if (!rst) begin
      n_vec++;
      if ((rise & fall) != 2'b00 || (rise4 & fall4) != 2'b00 ||
          changed !== |(rise | fall) || changed4 !== |(rise4 | fall4)) begin
        n_bad++;
        $display("FAIL pulse_sanity @%0t: rise=%b fall=%b changed=%b rise4=%b fall4=%b changed4=%b",
                 $time, rise, fall, changed, rise4, fall4, changed4);
      end
    end
  end

  initial begin
    int n_r, n_f, first, pulses;
    logic [1:0] dout_seen;

    tbl[0]  = '{2'b11, 8'd3,  2'b11, 2'b00, 2'b00, 1'b0};
    tbl[1]  = '{2'b01, 8'd21, 2'b11, 2'b00, 2'b00, 1'b0};
    tbl[2]  = '{2'b01, 8'd1,  2'b01, 2'b00, 2'b10, 1'b1};
    tbl[3]  = '{2'b01, 8'd1,  2'b01, 2'b00, 2'b00, 1'b0};
    tbl[4]  = '{2'b10, 8'd21, 2'b01, 2'b00, 2'b00, 1'b0};
    tbl[5]  = '{2'b10, 8'd1,  2'b10, 2'b10, 2'b01, 1'b1};
    tbl[6]  = '{2'b10, 8'd1,  2'b10, 2'b00, 2'b00, 1'b0};
    tbl[7]  = '{2'b00, 8'd22, 2'b00, 2'b00, 2'b10, 1'b1};
    tbl[8]  = '{2'b00, 8'd1,  2'b00, 2'b00, 2'b00, 1'b0};
    tbl[9]  = '{2'b01, 8'd20, 2'b00, 2'b00, 2'b00, 1'b0};
    tbl[10] = '{2'b00, 8'd2,  2'b01, 2'b01, 2'b00, 1'b1};
    tbl[11] = '{2'b00, 8'd1,  2'b01, 2'b00, 2'b00, 1'b0};
    tbl[12] = '{2'b00, 8'd18, 2'b01, 2'b00, 2'b00, 1'b0};
    tbl[13] = '{2'b00, 8'd1,  2'b00, 2'b00, 2'b01, 1'b1};
    tbl[14] = '{2'b00, 8'd1,  2'b00, 2'b00, 2'b00, 1'b0};

    // Reset held 3 edges with din=11, then full latency after release.
    rst  = 1'b1;
    din  = 2'b11;
    din4 = 2'b00;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_dout", 32'(dout), 32'(2'b00));
    end
    check("rst_pulses", 32'({rise, fall, changed}), 32'(0));
    rst = 1'b0;
    dout_seen = 2'b00;
    pulses = 0;
    for (int k = 1; k <= 21; k++) begin
      step();
      dout_seen = dout_seen | dout;
      pulses += int'(changed);
    end
    check("rel_early_dout", 32'(dout_seen), 32'(2'b00));
    check("rel_early_pulses", 32'(pulses), 32'(0));
    step();
    check("rel_e22_dout", 32'(dout), 32'(2'b11));
    check("rel_e22_rise", 32'(rise), 32'(2'b11));
    check("rel_e22_changed", 32'(changed), 32'(1));
    step();
    check("rel_e23_rise", 32'(rise), 32'(2'b00));
    check("rel_e23_changed", 32'(changed), 32'(0));

    for (int i = 0; i < 15; i++) begin
      din = tbl[i].din;
      for (int k = 0; k < int'(tbl[i].n); k++) step();
      check($sformatf("vec%0d_dout", i), 32'(dout), 32'(tbl[i].dout));
      check($sformatf("vec%0d_rise", i), 32'(rise), 32'(tbl[i].rise));
      check($sformatf("vec%0d_fall", i), 32'(fall), 32'(tbl[i].fall));
      check($sformatf("vec%0d_changed", i), 32'(changed), 32'(tbl[i].changed));
    end

    // 19-cycle glitch on din[0] must be rejected.
    dout_seen = 2'b00;
    pulses = 0;
    din = 2'b01;
    for (int k = 0; k < 19; k++) begin
      step();
      dout_seen = dout_seen | dout;
      pulses += int'(changed) + int'(rise != 0) + int'(fall != 0);
    end
    din = 2'b00;
    for (int k = 0; k < 25; k++) begin
      step();
      dout_seen = dout_seen | dout;
      pulses += int'(changed) + int'(rise != 0) + int'(fall != 0);
    end
    check("glitch19_dout", 32'(dout_seen), 32'(2'b00));
    check("glitch19_pulses", 32'(pulses), 32'(0));

    // din[0] toggles every 5 cycles for 40 cycles, then holds 1.
    n_r = 0;
    n_f = 0;
    for (int seg = 0; seg < 8; seg++) begin
      din = (seg % 2 == 0) ? 2'b01 : 2'b00;
      for (int k = 0; k < 5; k++) begin
        step();
        n_r += int'(rise[0]);
        n_f += int'(fall[0]);
      end
    end
    check("toggle_pulses", 32'(n_r + n_f), 32'(0));
    din = 2'b01;
    first = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (rise[0]) begin
        n_r++;
        if (first == 0) first = k;
      end
      n_f += int'(fall[0]);
    end
    check("toggle_rise_count", 32'(n_r), 32'(1));
    check("toggle_rise_edge", 32'(first), 32'(22));
    check("toggle_fall_count", 32'(n_f), 32'(0));

    // Reset mid-settle with counter at 10, din[0] still high afterwards.
    din = 2'b00;
    for (int k = 0; k < 22; k++) step();
    check("pre_abort_dout", 32'(dout), 32'(2'b00));
    din = 2'b01;
    for (int k = 0; k < 12; k++) step();
    rst = 1'b1;
    step();
    check("abort_dout", 32'(dout), 32'(2'b00));
    check("abort_pulses", 32'({rise, fall, changed}), 32'(0));
    rst = 1'b0;
    n_r = 0;
    n_f = 0;
    first = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (rise[0]) begin
        n_r++;
        if (first == 0) first = k;
      end
      n_f += int'(fall != 0);
    end
    check("abort_rise_edge", 32'(first), 32'(22));
    check("abort_rise_count", 32'(n_r), 32'(1));
    check("abort_fall_count", 32'(n_f), 32'(0));

    // PRESCALE=4: din4[1] rises, accepted 79..82 edges later.
    din4 = 2'b10;
    n_r = 0;
    first = 0;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (rise4[1]) begin
        n_r++;
        if (first == 0) first = k;
      end
    end
    if (first < 79 || first > 82) begin
      n_vec++;
      n_bad++;
      $display("FAIL p4_latency: got %0d, expected 79..82", first);
    end else begin
      n_vec++;
    end
    check("p4_rise_count", 32'(n_r), 32'(1));
    check("p4_dout", 32'(dout4), 32'(2'b10));
    check("p4_rise0_none", 32'(rise4[0]), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
